// File: rtl/barrett_sequencer_if.sv
// Bundles the request, multiplier and result handshakes of the Barrett sequencer.
// The master modport is the sequencer side. The slave modport is the environment side.
interface barrett_sequencer_if #(
    parameter int unsigned W  = 64,
    parameter int unsigned KW = 7
);
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] z;
    logic [W-1:0]   q;
    logic [W-1:0]   mu;
    logic [KW-1:0]  k;

    logic           mul_start;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic           mul_done;
    logic [2*W-1:0] mul_p;

    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   t;
    logic           err;
    logic [1:0]     n_corr;
    logic           busy;

    modport master (
        input  in_valid, z, q, mu, k, mul_done, mul_p, out_ready,
        output in_ready, mul_start, mul_a, mul_b, out_valid, t, err, n_corr, busy
    );

    modport slave (
        output in_valid, z, q, mu, k, mul_done, mul_p, out_ready,
        input  in_ready, mul_start, mul_a, mul_b, out_valid, t, err, n_corr, busy
    );
endinterface

// File: rtl/barrett_sequencer.sv
// Sequences one Barrett reduction t = z mod q over a shared external WxW multiplier.
// The subtract and the final correction steps are done locally.
module barrett_sequencer #(
    parameter int unsigned W  = 64,
    parameter int unsigned KW = 7
) (
    input logic                 clk,
    input logic                 rst,
    barrett_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        StIdle, StMul1, StWait1, StMul2, StWait2, StCorr, StDone
    } state_e;

    state_e        state_q, state_d;
    logic [W:0]    z_lo_q, z_lo_d;
    logic [W-1:0]  q_q, q_d;
    logic [KW-1:0] k_q, k_d;
    logic [W:0]    r_q, r_d;

    logic          in_ready_q, in_ready_d;
    logic          busy_q, busy_d;
    logic          mul_start_q, mul_start_d;
    logic [W-1:0]  mul_a_q, mul_a_d;
    logic [W-1:0]  mul_b_q, mul_b_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  t_q, t_d;
    logic          err_q, err_d;
    logic [1:0]    n_corr_q, n_corr_d;

    logic          req_bad;
    logic [W:0]    r_mask;
    logic [W:0]    r_sub;
    logic [W:0]    r_new;
    logic          r_ge_q;

    always_comb begin
        req_bad = (bus.q == '0) || (bus.k == '0) || (32'(bus.k) >= W) ||
                  ((bus.z >> {bus.k, 1'b0}) != '0);
        // Only the low k+1 bits of z - q3*q are significant; the rest wraps away.
        r_mask  = ((W+1)'(1) << (k_q + KW'(1))) - (W+1)'(1);
        r_sub   = (z_lo_q - bus.mul_p[W:0]) & r_mask;
        r_ge_q  = r_q >= {1'b0, q_q};
        r_new   = r_q - {1'b0, q_q};
    end

    always_comb begin
        state_d     = state_q;
        z_lo_d      = z_lo_q;
        q_d         = q_q;
        k_d         = k_q;
        r_d         = r_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        mul_start_d = 1'b0;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        out_valid_d = out_valid_q;
        t_d         = t_q;
        err_d       = err_q;
        n_corr_d    = n_corr_q;

        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    z_lo_d     = bus.z[W:0];
                    q_d        = bus.q;
                    k_d        = bus.k;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    if (req_bad) begin
                        err_d       = 1'b1;
                        t_d         = '0;
                        n_corr_d    = '0;
                        out_valid_d = 1'b1;
                        state_d     = StDone;
                    end else begin
                        mul_start_d = 1'b1;
                        mul_a_d     = W'(bus.z >> (bus.k - KW'(1)));
                        mul_b_d     = bus.mu;
                        state_d     = StMul1;
                    end
                end
            end
            StMul1: state_d = StWait1;
            StWait1: begin
                if (bus.mul_done) begin
                    mul_start_d = 1'b1;
                    mul_a_d     = W'(bus.mul_p >> (k_q + KW'(1)));
                    mul_b_d     = q_q;
                    state_d     = StMul2;
                end
            end
            StMul2: state_d = StWait2;
            StWait2: begin
                if (bus.mul_done) begin
                    r_d      = r_sub;
                    mul_a_d  = '0;
                    mul_b_d  = '0;
                    n_corr_d = '0;
                    state_d  = StCorr;
                end
            end
            StCorr: begin
                if (r_ge_q) begin
                    if (n_corr_q == 2'd2) begin
                        // A third correction means mu did not match q.
                        err_d       = 1'b1;
                        t_d         = W'(r_new);
                        n_corr_d    = 2'd3;
                        out_valid_d = 1'b1;
                        state_d     = StDone;
                    end else begin
                        r_d      = r_new;
                        n_corr_d = n_corr_q + 2'd1;
                    end
                end else begin
                    t_d         = W'(r_q);
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    t_d         = '0;
                    err_d       = 1'b0;
                    n_corr_d    = '0;
                    r_d         = '0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            z_lo_q      <= '0;
            q_q         <= '0;
            k_q         <= '0;
            r_q         <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            out_valid_q <= 1'b0;
            t_q         <= '0;
            err_q       <= 1'b0;
            n_corr_q    <= '0;
        end else begin
            state_q     <= state_d;
            z_lo_q      <= z_lo_d;
            q_q         <= q_d;
            k_q         <= k_d;
            r_q         <= r_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            mul_start_q <= mul_start_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            out_valid_q <= out_valid_d;
            t_q         <= t_d;
            err_q       <= err_d;
            n_corr_q    <= n_corr_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.mul_start = mul_start_q;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.out_valid = out_valid_q;
    assign bus.t         = t_q;
    assign bus.err       = err_q;
    assign bus.n_corr    = n_corr_q;
endmodule

// File: tb/tb_barrett_sequencer.sv
// Directed bench for barrett_sequencer with a behavioural multiplier of configurable latency.
module tb_barrett_sequencer;
    localparam int unsigned W  = 64;
    localparam int unsigned KW = 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    barrett_sequencer_if #(.W(W), .KW(KW)) bus ();
    barrett_sequencer #(.W(W), .KW(KW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int unsigned    mul_lat  = 1;
    int unsigned    n_starts = 0;
    logic           md_model = 1'b0;
    logic           md_spur  = 1'b0;
    logic [2*W-1:0] mp_model = '0;
    logic [W-1:0]   rec_a [64];
    logic [W-1:0]   rec_b [64];

    assign bus.mul_done = md_model | md_spur;
    assign bus.mul_p    = mp_model;

    initial begin : mul_model
        logic [W-1:0] a;
        logic [W-1:0] b;
        forever begin
            @(negedge clk);
            if (bus.mul_start) begin
                a = bus.mul_a;
                b = bus.mul_b;
                rec_a[n_starts % 64] = a;
                rec_b[n_starts % 64] = b;
                n_starts++;
                repeat (mul_lat) @(posedge clk);
                #1;
                md_model = 1'b1;
                mp_model = (2*W)'(a) * (2*W)'(b);
                @(posedge clk);
                #1;
                md_model = 1'b0;
                mp_model = '0;
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    int           r_lat;
    logic [W-1:0] r_t;
    logic         r_err;
    logic [1:0]   r_nc;

    task automatic run_req(input logic [2*W-1:0] z, input logic [W-1:0] q, input logic [W-1:0] mu,
                           input logic [KW-1:0] k, input int unsigned lat, input int hold);
        int cyc;
        mul_lat = lat;
        @(negedge clk);
        check_eq("in_ready_before_req", 128'(bus.in_ready), 128'd1);
        bus.in_valid  = 1'b1;
        bus.z         = z;
        bus.q         = q;
        bus.mu        = mu;
        bus.k         = k;
        bus.out_ready = (hold == 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        cyc = 1;
        while (!bus.out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.out_valid) check_eq("out_valid_timeout", 128'(bus.out_valid), 128'd1);
        r_lat = cyc;
        r_t   = bus.t;
        r_err = bus.err;
        r_nc  = bus.n_corr;
        for (int i = 0; i < hold; i++) begin
            md_spur = (i == 0);
            @(negedge clk);
            md_spur = 1'b0;
            check_eq("hold_t_stable", 128'(bus.t), 128'(r_t));
            check_eq("hold_n_corr_stable", 128'(bus.n_corr), 128'(r_nc));
            check_eq("hold_in_ready_low", 128'(bus.in_ready), 128'd0);
            check_eq("hold_out_valid", 128'(bus.out_valid), 128'd1);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_eq("out_valid_drops", 128'(bus.out_valid), 128'd0);
        check_eq("in_ready_returns", 128'(bus.in_ready), 128'd1);
    endtask

    task automatic err_case(input string tag, input logic [2*W-1:0] z, input logic [W-1:0] q,
                            input logic [KW-1:0] k);
        int unsigned base;
        base = n_starts;
        run_req(z, q, 64'd8736, k, 1, 0);
        check_eq({tag, "_err"}, 128'(r_err), 128'd1);
        check_eq({tag, "_t"}, 128'(r_t), 128'd0);
        check_eq({tag, "_lat"}, 128'(r_lat), 128'd1);
        check_eq({tag, "_no_start"}, 128'(n_starts - base), 128'd0);
    endtask

    initial begin : main
        int unsigned  base;
        logic [W-1:0] qb;
        logic [W-1:0] mub;
        logic [2*W-1:0] zb;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.z         = '0;
        bus.q         = '0;
        bus.mu        = '0;
        bus.k         = '0;
        rst           = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", 128'(bus.in_ready), 128'd1);
        check_eq("rst_busy", 128'(bus.busy), 128'd0);
        check_eq("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check_eq("rst_mul_start", 128'(bus.mul_start), 128'd0);
        check_eq("rst_t", 128'(bus.t), 128'd0);
        rst = 1'b0;

        // Case 1: no correction, L=1.
        base = n_starts;
        run_req(128'd3651363, 64'd7681, 64'd8736, 7'd13, 1, 0);
        check_eq("c1_lat", 128'(r_lat), 128'd6);
        check_eq("c1_t", 128'(r_t), 128'd2888);
        check_eq("c1_n_corr", 128'(r_nc), 128'd0);
        check_eq("c1_err", 128'(r_err), 128'd0);
        check_eq("c1_starts", 128'(n_starts - base), 128'd2);
        check_eq("c1_a0", 128'(rec_a[base % 64]), 128'd891);
        check_eq("c1_b0", 128'(rec_b[base % 64]), 128'd8736);
        check_eq("c1_a1", 128'(rec_a[(base + 1) % 64]), 128'd475);
        check_eq("c1_b1", 128'(rec_b[(base + 1) % 64]), 128'd7681);

        // Case 2: z = q*q - 1 needs one correction.
        base = n_starts;
        run_req(128'd58997760, 64'd7681, 64'd8736, 7'd13, 1, 0);
        check_eq("c2_lat", 128'(r_lat), 128'd7);
        check_eq("c2_t", 128'(r_t), 128'd7680);
        check_eq("c2_n_corr", 128'(r_nc), 128'd1);
        check_eq("c2_q3", 128'(rec_a[(base + 1) % 64]), 128'd7679);

        // Case 3: spurious done in IDLE, then L=5 with a stalled consumer.
        @(negedge clk);
        md_spur = 1'b1;
        @(negedge clk);
        md_spur = 1'b0;
        @(negedge clk);
        check_eq("spur_idle_busy", 128'(bus.busy), 128'd0);
        check_eq("spur_idle_out_valid", 128'(bus.out_valid), 128'd0);
        base = n_starts;
        run_req(128'd3651363, 64'd7681, 64'd8736, 7'd13, 5, 4);
        check_eq("c3_lat", 128'(r_lat), 128'd14);
        check_eq("c3_t", 128'(r_t), 128'd2888);
        check_eq("c3_starts", 128'(n_starts - base), 128'd2);

        err_case("q_zero", 128'd3651363, 64'd0, 7'd13);
        err_case("k_64", 128'd3651363, 64'd7681, 7'd64);
        err_case("z_wide", 128'd1 << 26, 64'd7681, 7'd13);

        // Reset while waiting for the second product; that product arrives after reset.
        mul_lat = 5;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.z         = 128'd3651363;
        bus.q         = 64'd7681;
        bus.mu        = 64'd8736;
        bus.k         = 7'd13;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("rst_mid_busy", 128'(bus.busy), 128'd1);
        check_eq("rst_mid_mul_a", 128'(bus.mul_a), 128'd475);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_mid_in_ready", 128'(bus.in_ready), 128'd1);
        check_eq("rst_mid_mul_a0", 128'(bus.mul_a), 128'd0);
        check_eq("rst_mid_mul_b0", 128'(bus.mul_b), 128'd0);
        check_eq("rst_mid_out_valid", 128'(bus.out_valid), 128'd0);
        repeat (4) @(negedge clk);
        check_eq("late_done_busy", 128'(bus.busy), 128'd0);
        check_eq("late_done_in_ready", 128'(bus.in_ready), 128'd1);
        check_eq("late_done_out_valid", 128'(bus.out_valid), 128'd0);
        check_eq("late_done_mul_start", 128'(bus.mul_start), 128'd0);
        run_req(128'd3651363, 64'd7681, 64'd8736, 7'd13, 1, 0);
        check_eq("after_rst_t", 128'(r_t), 128'd2888);
        check_eq("after_rst_lat", 128'(r_lat), 128'd6);

        // Full-width requests.
        err_case("w64_k64", 128'd12345, 64'h8000_0000_0000_001D, 7'd64);
        qb  = 64'h4000_0000_0000_0039;
        zb  = (2*W)'(qb) * (2*W)'(qb) - 128'd1;
        mub = W'((128'd1 << 126) / (2*W)'(qb));
        run_req(zb, qb, mub, 7'd63, 2, 0);
        check_eq("w64_t", 128'(r_t), 128'(qb - 64'd1));
        check_eq("w64_err", 128'(r_err), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
